// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-macro signals of the unified-memory port arbiter.
// master = arbiter side, slave = pipeline/memory environment side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_cancel;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;

  logic              stall_if;
  logic              stall_mem;

  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;

  modport master (
    input  if_req, if_addr, if_cancel,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  m_rdata,
    output if_rdata, if_valid, mem_rdata, mem_done,
    output stall_if, stall_mem,
    output m_en, m_we, m_addr, m_wdata
  );

  modport slave (
    output if_req, if_addr, if_cancel,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output m_rdata,
    input  if_rdata, if_valid, mem_rdata, mem_done,
    input  stall_if, stall_mem,
    input  m_en, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory between IF and MEM (MEM wins); pulse 2+MEM_LAT cycles after grant.
// Requesters hold req and are stalled until their valid/done pulse; no queueing beyond the held req.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.master bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  localparam int CNT_W = 4;

  logic [1:0]        state_q,     state_d;
  logic              owner_q,     owner_d;
  logic              drop_q,      drop_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic              acc_we_q,    acc_we_d;
  logic              m_en_q,      m_en_d;
  logic              m_we_q,      m_we_d;
  logic [ADDR_W-1:0] m_addr_q,    m_addr_d;
  logic [DATA_W-1:0] m_wdata_q,   m_wdata_d;
  logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              if_valid_q,  if_valid_d;
  logic              mem_done_q,  mem_done_d;

  logic cancel_hit;
  logic last_wait;

  // A cancel in the final WAIT cycle must still suppress that cycle's capture.
  assign cancel_hit = bus.if_cancel & (owner_q == OWN_IF);
  assign last_wait  = (cnt_q == CNT_W'(1));

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    drop_d      = drop_q;
    cnt_d       = cnt_q;
    acc_we_d    = acc_we_q;
    m_en_d      = 1'b0;
    m_we_d      = 1'b0;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_valid_d  = 1'b0;
    mem_done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        drop_d = 1'b0;
        if (bus.mem_req) begin
          owner_d   = OWN_MEM;
          acc_we_d  = bus.mem_we;
          m_en_d    = 1'b1;
          m_we_d    = bus.mem_we;
          m_addr_d  = bus.mem_addr;
          m_wdata_d = bus.mem_wdata;
          state_d   = S_ISSUE;
        end else if (bus.if_req) begin
          owner_d  = OWN_IF;
          acc_we_d = 1'b0;
          m_en_d   = 1'b1;
          m_addr_d = bus.if_addr;
          state_d  = S_ISSUE;
        end
      end

      S_ISSUE: begin
        cnt_d   = CNT_W'(MEM_LAT);
        state_d = S_WAIT;
        if (cancel_hit) begin
          drop_d = 1'b1;
        end
      end

      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cancel_hit) begin
          drop_d = 1'b1;
        end
        if (last_wait) begin
          if ((owner_q == OWN_IF) && (drop_q || cancel_hit)) begin
            drop_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
            if (owner_q == OWN_IF) begin
              if_rdata_d = bus.m_rdata;
              if_valid_d = 1'b1;
            end else begin
              if (!acc_we_q) begin
                mem_rdata_d = bus.m_rdata;
              end
              mem_done_d = 1'b1;
            end
          end
        end
      end

      S_DONE: begin
        drop_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_IF;
      drop_q      <= 1'b0;
      cnt_q       <= '0;
      acc_we_q    <= 1'b0;
      m_en_q      <= 1'b0;
      m_we_q      <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_valid_q  <= 1'b0;
      mem_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      drop_q      <= drop_d;
      cnt_q       <= cnt_d;
      acc_we_q    <= acc_we_d;
      m_en_q      <= m_en_d;
      m_we_q      <= m_we_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_valid_q  <= if_valid_d;
      mem_done_q  <= mem_done_d;
    end
  end

  assign bus.m_en      = m_en_q;
  assign bus.m_we      = m_we_q;
  assign bus.m_addr    = m_addr_q;
  assign bus.m_wdata   = m_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.mem_done  = mem_done_q;
  assign bus.stall_if  = bus.if_req & ~if_valid_q;
  assign bus.stall_mem = bus.mem_req & ~mem_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (MEM_LAT=2): stimulus pushes expected issues/responses,
// negedge monitors pop and compare whenever the DUT pulses m_en, if_valid or mem_done.
module tb_mem_port_arbiter;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } iss_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } rsp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_pass;
  int   n_total;

  iss_t exp_iss[$];
  rsp_t exp_if[$];
  rsp_t exp_mem[$];

  logic [31:0] mem_arr [logic [31:0]];
  logic [31:0] pd0, pd1;
  logic        pv0, pv1;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: data appears exactly two cycles after the m_en cycle, poison otherwise.
  always @(posedge clk) begin
    logic [31:0] rd;
    rd = 32'h0;
    if (bus.m_en) begin
      if (mem_arr.exists(bus.m_addr)) rd = mem_arr[bus.m_addr];
      if (bus.m_we) mem_arr[bus.m_addr] = bus.m_wdata;
    end
    pv0 <= bus.m_en;
    pd0 <= rd;
    pv1 <= pv0;
    pd1 <= pd0;
  end
  assign bus.m_rdata = pv1 ? pd1 : 32'hBAD0BAD0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_evt(input string name);
    n_total++;
    $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_iss.size() != 0 || exp_if.size() != 0 || exp_mem.size() != 0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) fail_evt("drain_timeout");
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.m_en) begin
        if (exp_iss.size() == 0) fail_evt("m_en_extra");
        else begin
          iss_t e;
          e = exp_iss.pop_front();
          chk("issue_cycle", cyc, e.cyc);
          chk("issue_addr", bus.m_addr, e.addr);
          chk("issue_we", {31'd0, bus.m_we}, {31'd0, e.we});
          if (e.we) chk("issue_wdata", bus.m_wdata, e.wdata);
        end
      end
      if (bus.if_valid) begin
        if (exp_if.size() == 0) fail_evt("if_valid_extra");
        else begin
          rsp_t r;
          r = exp_if.pop_front();
          chk("if_valid_cycle", cyc, r.cyc);
          chk("if_rdata", bus.if_rdata, r.data);
        end
      end
      if (bus.mem_done) begin
        if (exp_mem.size() == 0) fail_evt("mem_done_extra");
        else begin
          rsp_t r;
          r = exp_mem.pop_front();
          chk("mem_done_cycle", cyc, r.cyc);
          chk("mem_rdata", bus.mem_rdata, r.data);
        end
      end
    end
  end

  task automatic chk_regs_zero(input string tag);
    chk({tag, "_m_en"},      {31'd0, bus.m_en}, 32'd0);
    chk({tag, "_m_we"},      {31'd0, bus.m_we}, 32'd0);
    chk({tag, "_m_addr"},    bus.m_addr, 32'd0);
    chk({tag, "_m_wdata"},   bus.m_wdata, 32'd0);
    chk({tag, "_if_rdata"},  bus.if_rdata, 32'd0);
    chk({tag, "_mem_rdata"}, bus.mem_rdata, 32'd0);
    chk({tag, "_if_valid"},  {31'd0, bus.if_valid}, 32'd0);
    chk({tag, "_mem_done"},  {31'd0, bus.mem_done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    n_pass  = 0;
    n_total = 0;
    mem_arr[32'h40] = 32'hDEADBEEF;
    mem_arr[32'h80] = 32'hCAFEF00D;
    mem_arr[32'hC0] = 32'h13579BDF;
    reset         = 1'b1;
    bus.if_req    = 1'b0;
    bus.if_addr   = 32'h0;
    bus.if_cancel = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    #3;
    chk_regs_zero("reset");
    chk("reset_stall_if", {31'd0, bus.stall_if}, 32'd0);
    chk("reset_stall_mem", {31'd0, bus.stall_mem}, 32'd0);
    repeat (3) step();
    reset = 1'b0;
    repeat (2) step();

    // Single fetch
    t = cyc;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h40;
    exp_iss.push_back('{t + 1, 32'h40, 1'b0, 32'h0});
    exp_if.push_back('{t + 4, 32'hDEADBEEF});
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("fetch_stall_if", {31'd0, bus.stall_if}, (k < 4) ? 32'd1 : 32'd0);
      step();
    end
    bus.if_req = 1'b0;
    wait_drain(20);
    repeat (2) step();

    // Store then load, mem_req held high through the DONE cycles
    t = cyc;
    bus.mem_req   = 1'b1;
    bus.mem_we    = 1'b1;
    bus.mem_addr  = 32'h100;
    bus.mem_wdata = 32'h12345678;
    exp_iss.push_back('{t + 1, 32'h100, 1'b1, 32'h12345678});
    exp_mem.push_back('{t + 4, 32'h0});
    exp_iss.push_back('{t + 6, 32'h100, 1'b0, 32'h0});
    exp_mem.push_back('{t + 9, 32'h12345678});
    step(); step();
    #1 chk("store_stall_mem", {31'd0, bus.stall_mem}, 32'd1);
    step(); step();
    #1 chk("done_stall_mem", {31'd0, bus.stall_mem}, 32'd0);
    step();
    bus.mem_we    = 1'b0;
    bus.mem_wdata = 32'h0;
    repeat (5) step();
    bus.mem_req = 1'b0;
    wait_drain(20);
    repeat (2) step();

    // Contention: MEM first, IF after; a cancel during a MEM access is ignored
    t = cyc;
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h80;
    bus.mem_req  = 1'b1;
    bus.mem_addr = 32'h100;
    exp_iss.push_back('{t + 1, 32'h100, 1'b0, 32'h0});
    exp_mem.push_back('{t + 4, 32'h12345678});
    exp_iss.push_back('{t + 6, 32'h80, 1'b0, 32'h0});
    exp_if.push_back('{t + 9, 32'hCAFEF00D});
    for (int k = 0; k < 11; k++) begin
      bus.if_cancel = (k == 2);
      if (k == 5) bus.mem_req = 1'b0;
      if (k == 10) bus.if_req = 1'b0;
      #1;
      if (k < 10) chk("contend_stall_if", {31'd0, bus.stall_if}, (k < 9) ? 32'd1 : 32'd0);
      step();
    end
    wait_drain(20);
    repeat (2) step();

    // Cancel in WAIT: no pulse, re-grant in the IDLE cycle right after
    t = cyc;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h40;
    exp_iss.push_back('{t + 1, 32'h40, 1'b0, 32'h0});
    step(); step();
    bus.if_cancel = 1'b1;
    step();
    bus.if_cancel = 1'b0;
    bus.if_addr   = 32'hC0;
    exp_iss.push_back('{t + 5, 32'hC0, 1'b0, 32'h0});
    exp_if.push_back('{t + 8, 32'h13579BDF});
    step();
    #1;
    chk("cancel_if_rdata_held", bus.if_rdata, 32'hCAFEF00D);
    chk("cancel_stall_if", {31'd0, bus.stall_if}, 32'd1);
    repeat (5) step();
    bus.if_req = 1'b0;
    wait_drain(20);
    repeat (2) step();

    // Reset during WAIT abandons the load; a fresh fetch then runs normally
    t = cyc;
    bus.mem_req  = 1'b1;
    bus.mem_addr = 32'h100;
    exp_iss.push_back('{t + 1, 32'h100, 1'b0, 32'h0});
    step(); step();
    #2;
    reset       = 1'b1;
    bus.mem_req = 1'b0;
    #1;
    chk_regs_zero("midreset");
    step(); step();
    reset = 1'b0;
    repeat (6) step();
    t = cyc;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h40;
    exp_iss.push_back('{t + 1, 32'h40, 1'b0, 32'h0});
    exp_if.push_back('{t + 4, 32'hDEADBEEF});
    repeat (5) step();
    bus.if_req = 1'b0;
    wait_drain(20);
    repeat (4) step();

    chk("end_iss_queue_empty", exp_iss.size(), 32'd0);
    chk("end_if_queue_empty", exp_if.size(), 32'd0);
    chk("end_mem_queue_empty", exp_mem.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
